// File: rtl/divisor_algoritmico_seg_gen.sv
// Fully pipelined restoring divider: one operation per cycle, BITS_ETAPA quotient bits per stage,
// run-time signed/unsigned, tag pass-through, global Hold stall and defined divide-by-zero result.
module divisor_algoritmico_seg_gen #(
   parameter int unsigned tamanyo    = 32,
   parameter int unsigned BITS_ETAPA = 1,
   parameter int unsigned TAG_W      = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               Start,
   input  logic               Signed,
   input  logic [tamanyo-1:0] Num,
   input  logic [tamanyo-1:0] Den,
   input  logic [TAG_W-1:0]   Tag_in,
   input  logic               Hold,
   output logic [tamanyo-1:0] Coc,
   output logic [tamanyo-1:0] Res,
   output logic               DivZero,
   output logic [TAG_W-1:0]   Tag_out,
   output logic               Done
);

   localparam int unsigned W = tamanyo;
   localparam int unsigned N = tamanyo / BITS_ETAPA;

   generate
      if (tamanyo % BITS_ETAPA != 0) begin : g_bad_split
         $error("divisor_algoritmico_seg_gen: BITS_ETAPA must divide tamanyo exactly");
      end
      if (tamanyo < 4) begin : g_bad_width
         $error("divisor_algoritmico_seg_gen: tamanyo must be at least 4");
      end
   endgenerate

   // Operand capture register keeps the negation logic off the input pins.
   logic             cap_vld_q, cap_vld_d;
   logic             cap_sgn_q, cap_sgn_d;
   logic [W-1:0]     cap_num_q, cap_num_d;
   logic [W-1:0]     cap_den_q, cap_den_d;
   logic [TAG_W-1:0] cap_tag_q, cap_tag_d;

   // Index 0 is the input stage, 1..N are the iteration stages.
   logic [N:0]       vld_q, vld_d;
   logic [N:0]       nneg_q, nneg_d;
   logic [N:0]       dneg_q, dneg_d;
   logic [N:0]       dz_q, dz_d;
   logic [W-1:0]     acc_q [N+1];
   logic [W-1:0]     acc_d [N+1];
   logic [W-1:0]     quo_q [N+1];
   logic [W-1:0]     quo_d [N+1];
   logic [W-1:0]     div_q [N+1];
   logic [W-1:0]     div_d [N+1];
   logic [W-1:0]     num_q [N+1];
   logic [W-1:0]     num_d [N+1];
   logic [TAG_W-1:0] tag_q [N+1];
   logic [TAG_W-1:0] tag_d [N+1];

   logic             done_q, done_d;
   logic [W-1:0]     coc_q, coc_d;
   logic [W-1:0]     res_q, res_d;
   logic             divz_q, divz_d;
   logic [TAG_W-1:0] tago_q, tago_d;

   // The accumulator stays below the divisor between steps, so only the
   // shifted intermediate needs the extra bit.
   function automatic logic [2*W-1:0] etapa(input logic [W-1:0] acc_in,
                                            input logic [W-1:0] quo_in,
                                            input logic [W-1:0] m);
      logic [W:0]   acc;
      logic [W-1:0] quo;
      acc = {1'b0, acc_in};
      quo = quo_in;
      for (int unsigned b = 0; b < BITS_ETAPA; b++) begin
         acc = {acc[W-1:0], quo[W-1]};
         quo = {quo[W-2:0], 1'b0};
         if (acc >= {1'b0, m}) begin
            acc    = acc - {1'b0, m};
            quo[0] = 1'b1;
         end
      end
      return {acc[W-1:0], quo};
   endfunction

   always_comb begin
      cap_vld_d = cap_vld_q;
      cap_sgn_d = cap_sgn_q;
      cap_num_d = cap_num_q;
      cap_den_d = cap_den_q;
      cap_tag_d = cap_tag_q;
      vld_d     = vld_q;
      nneg_d    = nneg_q;
      dneg_d    = dneg_q;
      dz_d      = dz_q;
      acc_d     = acc_q;
      quo_d     = quo_q;
      div_d     = div_q;
      num_d     = num_q;
      tag_d     = tag_q;
      done_d    = done_q;
      coc_d     = coc_q;
      res_d     = res_q;
      divz_d    = divz_q;
      tago_d    = tago_q;

      if (!Hold) begin
         cap_vld_d = Start;
         cap_sgn_d = Signed;
         cap_num_d = Num;
         cap_den_d = Den;
         cap_tag_d = Tag_in;

         vld_d[0]  = cap_vld_q;
         nneg_d[0] = cap_sgn_q & cap_num_q[W-1];
         dneg_d[0] = cap_sgn_q & cap_den_q[W-1];
         dz_d[0]   = (cap_den_q == '0);
         acc_d[0]  = '0;
         quo_d[0]  = (cap_sgn_q & cap_num_q[W-1]) ? -cap_num_q : cap_num_q;
         div_d[0]  = (cap_sgn_q & cap_den_q[W-1]) ? -cap_den_q : cap_den_q;
         num_d[0]  = cap_num_q;
         tag_d[0]  = cap_tag_q;

         for (int unsigned s = 1; s <= N; s++) begin
            vld_d[s]              = vld_q[s-1];
            nneg_d[s]             = nneg_q[s-1];
            dneg_d[s]             = dneg_q[s-1];
            dz_d[s]               = dz_q[s-1];
            {acc_d[s], quo_d[s]}  = etapa(acc_q[s-1], quo_q[s-1], div_q[s-1]);
            div_d[s]              = div_q[s-1];
            num_d[s]              = num_q[s-1];
            tag_d[s]              = tag_q[s-1];
         end

         done_d = vld_q[N];
         divz_d = dz_q[N];
         tago_d = tag_q[N];
         if (dz_q[N]) begin
            coc_d = '1;
            res_d = num_q[N];
         end else begin
            coc_d = (nneg_q[N] ^ dneg_q[N]) ? -quo_q[N] : quo_q[N];
            res_d = nneg_q[N] ? -acc_q[N] : acc_q[N];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cap_vld_q <= 1'b0;
         vld_q     <= '0;
         done_q    <= 1'b0;
         coc_q     <= '0;
         res_q     <= '0;
         divz_q    <= 1'b0;
         tago_q    <= '0;
      end else begin
         cap_vld_q <= cap_vld_d;
         vld_q     <= vld_d;
         done_q    <= done_d;
         coc_q     <= coc_d;
         res_q     <= res_d;
         divz_q    <= divz_d;
         tago_q    <= tago_d;
      end
   end

   // Datapath contents are qualified by the valid bits and need no reset.
   always_ff @(posedge CLK) begin
      cap_sgn_q <= cap_sgn_d;
      cap_num_q <= cap_num_d;
      cap_den_q <= cap_den_d;
      cap_tag_q <= cap_tag_d;
      nneg_q    <= nneg_d;
      dneg_q    <= dneg_d;
      dz_q      <= dz_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      num_q     <= num_d;
      tag_q     <= tag_d;
   end

   assign Coc     = coc_q;
   assign Res     = res_q;
   assign DivZero = divz_q;
   assign Tag_out = tago_q;
   assign Done    = done_q;

endmodule

// File: tb/tb_divisor_algoritmico_seg_gen.sv
// Self-checking bench: three divider configurations share one stimulus stream and are
// compared every cycle against an arithmetic reference model with stall/reset tracking.
module tb_divisor_algoritmico_seg_gen;

   logic        CLK, RST, Start, Signed, Hold;
   logic [31:0] Num, Den;
   logic [5:0]  Tag_in;

   logic [31:0] coc0, res0, coc1, res1;
   logic [7:0]  coc2, res2;
   logic        dz0, dz1, dz2, dn0, dn1, dn2;
   logic [5:0]  tg0, tg1, tg2;

   divisor_algoritmico_seg_gen #(.tamanyo(32), .BITS_ETAPA(1), .TAG_W(6)) u_d32_1 (
      .CLK(CLK), .RST(RST), .Start(Start), .Signed(Signed), .Num(Num), .Den(Den),
      .Tag_in(Tag_in), .Hold(Hold), .Coc(coc0), .Res(res0), .DivZero(dz0),
      .Tag_out(tg0), .Done(dn0));

   divisor_algoritmico_seg_gen #(.tamanyo(32), .BITS_ETAPA(4), .TAG_W(6)) u_d32_4 (
      .CLK(CLK), .RST(RST), .Start(Start), .Signed(Signed), .Num(Num), .Den(Den),
      .Tag_in(Tag_in), .Hold(Hold), .Coc(coc1), .Res(res1), .DivZero(dz1),
      .Tag_out(tg1), .Done(dn1));

   divisor_algoritmico_seg_gen #(.tamanyo(8), .BITS_ETAPA(2), .TAG_W(6)) u_d8_2 (
      .CLK(CLK), .RST(RST), .Start(Start), .Signed(Signed), .Num(Num[7:0]), .Den(Den[7:0]),
      .Tag_in(Tag_in), .Hold(Hold), .Coc(coc2), .Res(res2), .DivZero(dz2),
      .Tag_out(tg2), .Done(dn2));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [31:0] a_coc [3];
   logic [31:0] a_res [3];
   logic        a_dz  [3];
   logic [5:0]  a_tg  [3];
   logic        a_dn  [3];
   assign a_coc[0] = coc0;  assign a_res[0] = res0;  assign a_dz[0] = dz0;
   assign a_coc[1] = coc1;  assign a_res[1] = res1;  assign a_dz[1] = dz1;
   assign a_coc[2] = {24'b0, coc2};  assign a_res[2] = {24'b0, res2};  assign a_dz[2] = dz2;
   assign a_tg[0] = tg0;  assign a_tg[1] = tg1;  assign a_tg[2] = tg2;
   assign a_dn[0] = dn0;  assign a_dn[1] = dn1;  assign a_dn[2] = dn2;

   typedef struct {
      logic [31:0] num;
      logic [31:0] den;
      logic        sgn;
      logic [5:0]  tag;
      int          a;
      logic        fix;
      logic [31:0] fcoc;
      logic [31:0] fres;
      logic        fdz;
   } op_t;

   op_t         ops[$];
   int          hd   [3];
   int          lat  [3] = '{34, 10, 6};
   int unsigned wid  [3] = '{32, 32, 8};
   logic        mdone[3];
   logic [31:0] mcoc [3];
   logic [31:0] mres [3];
   logic        mdz  [3];
   logic [5:0]  mtag [3];
   int          act;
   int          n_chk, n_fail;

   logic        cur_fix, cur_fdz;
   logic [31:0] cur_fcoc, cur_fres;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Truncating division on sign-extended integers; remainder takes the dividend's sign.
   function automatic void ref_div(input logic [31:0] num, input logic [31:0] den,
                                   input logic sgn, input int unsigned w,
                                   output logic [31:0] coc, output logic [31:0] res,
                                   output logic dz);
      longint mask, n, d, sn, sd;
      mask = (longint'(1) << w) - 1;
      n    = longint'(num) & mask;
      d    = longint'(den) & mask;
      if (d == 0) begin
         coc = 32'(mask);
         res = 32'(n);
         dz  = 1'b1;
         return;
      end
      sn = n;
      sd = d;
      if (sgn) begin
         if (n >= (longint'(1) << (w - 1))) sn = n - (longint'(1) << w);
         if (d >= (longint'(1) << (w - 1))) sd = d - (longint'(1) << w);
      end
      coc = 32'((sn / sd) & mask);
      res = 32'((sn % sd) & mask);
      dz  = 1'b0;
   endfunction

   task automatic tick();
      logic rst_e;
      op_t  o;
      @(posedge CLK);
      rst_e = RST;
      if (RST) begin
         for (int d = 0; d < 3; d++) begin
            hd[d]    = ops.size();
            mdone[d] = 1'b0;
         end
      end else if (!Hold) begin
         act++;
         if (Start) begin
            o.num = Num;  o.den = Den;  o.sgn = Signed;  o.tag = Tag_in;  o.a = act;
            o.fix = cur_fix;  o.fcoc = cur_fcoc;  o.fres = cur_fres;  o.fdz = cur_fdz;
            ops.push_back(o);
         end
         for (int d = 0; d < 3; d++) begin
            mdone[d] = 1'b0;
            if (hd[d] < ops.size() && ops[hd[d]].a + lat[d] == act) begin
               o = ops[hd[d]];
               if (o.fix && wid[d] == 32) begin
                  mcoc[d] = o.fcoc;  mres[d] = o.fres;  mdz[d] = o.fdz;
               end else begin
                  ref_div(o.num, o.den, o.sgn, wid[d], mcoc[d], mres[d], mdz[d]);
               end
               mtag[d]  = o.tag;
               mdone[d] = 1'b1;
               hd[d]++;
            end
         end
      end
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("done[%0d]", d), 64'(a_dn[d]), 64'(mdone[d]));
         if (rst_e) begin
            chk($sformatf("rst_coc[%0d]", d), 64'(a_coc[d]), 64'(0));
            chk($sformatf("rst_res[%0d]", d), 64'(a_res[d]), 64'(0));
            chk($sformatf("rst_dz[%0d]", d),  64'(a_dz[d]),  64'(0));
            chk($sformatf("rst_tag[%0d]", d), 64'(a_tg[d]),  64'(0));
         end else if (mdone[d]) begin
            chk($sformatf("coc[%0d]", d), 64'(a_coc[d]), 64'(mcoc[d]));
            chk($sformatf("res[%0d]", d), 64'(a_res[d]), 64'(mres[d]));
            chk($sformatf("dz[%0d]", d),  64'(a_dz[d]),  64'(mdz[d]));
            chk($sformatf("tag[%0d]", d), 64'(a_tg[d]),  64'(mtag[d]));
         end
      end
   endtask

   task automatic issue(input logic [31:0] n, input logic [31:0] d, input logic s,
                        input logic [5:0] t, input logic fix, input logic [31:0] fc,
                        input logic [31:0] fr, input logic fz);
      Num = n;  Den = d;  Signed = s;  Tag_in = t;  Start = 1'b1;
      cur_fix = fix;  cur_fcoc = fc;  cur_fres = fr;  cur_fdz = fz;
      tick();
      Start = 1'b0;  cur_fix = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic [31:0] rnd_num();
      case ($urandom % 8)
         0:       return 32'h8000_0000;
         1:       return 32'h0000_0080;
         2:       return $urandom % 256;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [31:0] rnd_den();
      case ($urandom % 8)
         0:       return 32'h0;
         1:       return $urandom_range(1, 5);
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0000_0080;
         4:       return $urandom % 256;
         default: return $urandom;
      endcase
   endfunction

   task automatic issue_rnd(input logic [5:0] t);
      issue(rnd_num(), rnd_den(), 1'($urandom % 2), t, 1'b0, '0, '0, 1'b0);
   endtask

   initial begin
      n_chk = 0;  n_fail = 0;  act = 0;
      RST = 1'b1;  Hold = 1'b0;  Start = 1'b0;  Signed = 1'b0;
      Num = '0;  Den = '0;  Tag_in = '0;
      cur_fix = 1'b0;  cur_fcoc = '0;  cur_fres = '0;  cur_fdz = 1'b0;
      for (int d = 0; d < 3; d++) begin
         hd[d] = 0;  mdone[d] = 1'b0;  mcoc[d] = '0;  mres[d] = '0;  mdz[d] = 1'b0;  mtag[d] = '0;
      end
      idle(2);
      RST = 1'b0;
      idle(2);

      // Directed cases with hand-derived 32-bit results.
      issue(32'd100,        32'd7,          1'b0, 6'd3, 1'b1, 32'd14,         32'd2,          1'b0);
      issue(32'hFFFF_FFFF,  32'd2,          1'b0, 6'd4, 1'b1, 32'h7FFF_FFFF,  32'd1,          1'b0);
      issue(32'hFFFF_FFF9,  32'd2,          1'b1, 6'd5, 1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
      issue(32'd7,          32'hFFFF_FFFE,  1'b1, 6'd6, 1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0);
      issue(32'hFFFF_FFF9,  32'd2,          1'b0, 6'd7, 1'b1, 32'h7FFF_FFFC,  32'd1,          1'b0);
      issue(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 6'd8, 1'b1, 32'h8000_0000,  32'd0,          1'b0);
      issue(32'h0000_1234,  32'd0,          1'b1, 6'd9, 1'b1, 32'hFFFF_FFFF,  32'h0000_1234,  1'b1);
      issue(32'h0000_1234,  32'd0,          1'b0, 6'd10, 1'b1, 32'hFFFF_FFFF, 32'h0000_1234,  1'b1);
      idle(40);

      for (int i = 0; i < 40; i++) issue_rnd(6'(i));
      idle(40);

      // Stall mid-flight with Starts presented while held.
      for (int i = 0; i < 3; i++) issue_rnd(6'(50 + i));
      idle(5);
      Hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         Num = $urandom;  Den = $urandom;  Tag_in = 6'(60 + i);  Start = 1'b1;
         tick();
      end
      Hold = 1'b0;  Start = 1'b0;
      idle(40);

      // Reset while operations are in flight, asserted together with Hold.
      for (int i = 0; i < 5; i++) issue_rnd(6'(20 + i));
      idle(5);
      RST = 1'b1;  Hold = 1'b1;
      tick();
      RST = 1'b0;  Hold = 1'b0;
      idle(3);
      issue(32'd100, 32'd7, 1'b0, 6'd33, 1'b1, 32'd14, 32'd2, 1'b0);
      idle(40);

      for (int d = 0; d < 3; d++) chk($sformatf("drained[%0d]", d), 64'(hd[d]), 64'(ops.size()));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/divisor_algoritmico_seg_gen.md
Name: divisor_algoritmico_seg_gen

Overview:
Fully pipelined restoring integer divider, next generation of the segmented divider.
- Generalised: width, bits resolved per pipeline stage, run-time signed/unsigned mode, tag pass-through, global stall, defined divide-by-zero result.
- Accepts one division per cycle and returns quotient/remainder a fixed number of cycles later.
- Sits in the datapath behind the test interface as a drop-in throughput divider.

Parameters:
tamanyo, 32, operand/result width in bits (>=4).
BITS_ETAPA, 1, quotient bits resolved per iteration stage; must divide tamanyo exactly, else elaboration error.
TAG_W, 4, width of the user tag carried alongside each operation.

Ports:
CLK  input  1  clock, all logic on rising edge.
RST  input  1  synchronous, active-high reset.
Start  input  1  operation valid; sampled only when Hold=0.
Signed  input  1  1 = two's-complement division, 0 = unsigned; sampled with Start.
Num  input  tamanyo  dividend.
Den  input  tamanyo  divisor.
Tag_in  input  TAG_W  user tag, sampled with Start.
Hold  input  1  freezes the entire pipeline while high.
Coc  output  tamanyo  quotient (registered).
Res  output  tamanyo  remainder (registered).
DivZero  output  1  Den was zero for the result on Coc/Res.
Tag_out  output  TAG_W  tag of the result on Coc/Res.
Done  output  1  one-cycle-per-result valid for Coc/Res/DivZero/Tag_out.

Behaviour:
- Reset is synchronous: RST high at a rising edge clears every stage valid bit, Done, DivZero, Coc, Res and Tag_out to 0. Reset mid-operation discards all in-flight operations; no Done pulse follows.
- Structure: N = tamanyo/BITS_ETAPA iteration stages between an input stage and an output stage.
- Latency: L = N+2 cycles. Start sampled at edge k gives Done=1 after edge k+L (tamanyo=32, BITS_ETAPA=1 gives L=34).
- Throughput: one operation per non-held cycle. Back-to-back Starts produce back-to-back Done pulses in issue order.
- Input stage:
  - Registers Signed, Tag_in and DivZero = (Den==0).
  - Registers the sign flags: Num[MSB]&Signed and Den[MSB]&Signed.
  - Registers the magnitudes |Num| and |Den|; unsigned mode takes operands as-is.
  - Accumulator is cleared.
- Iteration stage: performs BITS_ETAPA restoring steps combinationally. Each step:
  - Shift {ACC,Q} left by 1.
  - If ACC >= M, then ACC -= M and set Q[0]=1.
  - ACC carries tamanyo+1 bits internally so no comparison overflows.
- Output stage:
  - Coc = negated Q when the two sign flags differ, else Q.
  - Res = negated ACC when the dividend sign flag is set, else ACC. Remainder sign follows the dividend; |Res| < |Den|.
- Divide by zero (DivZero=1): Coc = all ones, Res = original Num (carried through the pipe), in both modes.
- Signed overflow (most-negative / -1): Coc = most-negative value, Res = 0, DivZero=0.
- Hold=1:
  - No register changes.
  - Start/operands ignored.
  - Done and the other outputs hold their values. A Done high during Hold stays high and represents one result.
- Hold and RST together: RST wins.
- A stage whose valid bit is 0 may hold stale data. Coc/Res/Tag_out are don't-care while Done=0.

Test Plan:
- Unsigned, tamanyo=32, BITS_ETAPA=1: Num=100, Den=7, Tag_in=3 -> exactly 34 cycles later Done=1, Coc=14, Res=2, Tag_out=3, DivZero=0. Unsigned 0xFFFFFFFF/2 -> Coc=0x7FFFFFFF, Res=1.
- Signed: -7/2 -> Coc=0xFFFFFFFD, Res=0xFFFFFFFF. 7/-2 -> Coc=0xFFFFFFFD, Res=1. Same -7/2 operands with Signed=0 -> Coc=0x7FFFFFFC, Res=1.
- Corners: 0x80000000 / 0xFFFFFFFF signed -> Coc=0x80000000, Res=0, DivZero=0. 0x1234/0 -> Coc=0xFFFFFFFF, Res=0x1234, DivZero=1 in both modes.
- Streaming: 40 random back-to-back Starts with tags 0..39 -> 40 consecutive Done pulses, tags in order, results matching a reference model. Repeat with BITS_ETAPA=4 (L=10) and tamanyo=8, BITS_ETAPA=2 (L=6).
- Stall: issue 3 ops, assert Hold for 5 cycles mid-flight -> outputs frozen during Hold, Starts during Hold produce nothing, completion shifted by exactly 5 cycles.
- Reset mid-flight: issue 5 ops, pulse RST for 1 cycle after 10 cycles -> all outputs 0, no Done for those ops. A new op issued after reset completes in L cycles.
